truth_table_checker: RTL and testbench

- Synthesizable response-side counterpart to the team's exhaustive 4-input Boolean stimulus benches.
- Drives all 16 input combinations {A,B,C,D} (A = MSB), counting 0000 to 1111, into a combinational DUT.
- Holds each vector for a settle window, then samples the DUT output Y and compares it against an expected 16-bit truth table.
- Reports captured truth table, mismatch count, first failing vector and pass/fail. Sits beside boolean_expression_* blocks on the lab board/self-check harness.

---
 rtl/truth_table_checker_if.sv | 30 +++
 rtl/truth_table_checker.sv | 106 ++++++++++
 tb/tb_truth_table_checker.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/truth_table_checker_if.sv
// Signal bundle between the truth-table checker and the harness driving it and the combinational
// DUT under test. The checker is the slave; the harness/bench is the master.
interface truth_table_checker_if;
  logic        start;
  logic [15:0] expected;
  logic        y_in;
  logic        a_out;
  logic        b_out;
  logic        c_out;
  logic        d_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic        first_err_valid;
  logic [3:0]  first_err_vec;
  logic [15:0] captured;

  modport slave (
    input  start, expected, y_in,
    output a_out, b_out, c_out, d_out, busy, done, pass, err_count,
           first_err_valid, first_err_vec, captured
  );

  modport master (
    output start, expected, y_in,
    input  a_out, b_out, c_out, d_out, busy, done, pass, err_count,
           first_err_valid, first_err_vec, captured
  );
endinterface

// File: rtl/truth_table_checker.sv
// Sweeps all 16 {A,B,C,D} vectors into a combinational DUT, samples Y after a settle window
// and compares against a golden truth table latched at start.
module truth_table_checker #(
  parameter int unsigned HOLD_CYCLES = 10  // legal range 1..255
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_checker_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(HOLD_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  vec_q;
  logic [7:0]  cnt_q;
  logic [15:0] exp_q;
  logic [15:0] captured_q;
  logic        busy_q, done_q, pass_q;
  logic [4:0]  err_count_q;
  logic        first_err_valid_q;
  logic [3:0]  first_err_vec_q;

  logic        mismatch;
  logic        sample;
  logic [4:0]  err_count_d;

  always_comb begin
    mismatch    = (bus.y_in != exp_q[vec_q]);
    sample      = (cnt_q == CntLast);
    err_count_d = err_count_q + 5'(mismatch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StIdle;
      vec_q             <= '0;
      cnt_q             <= '0;
      exp_q             <= '0;
      captured_q        <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_vec_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            exp_q             <= bus.expected;
            vec_q             <= '0;
            cnt_q             <= '0;
            captured_q        <= '0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_vec_q   <= '0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            busy_q            <= 1'b1;
            state_q           <= StRun;
          end
        end
        StRun: begin
          if (sample) begin
            captured_q[vec_q] <= bus.y_in;
            cnt_q             <= '0;
            if (mismatch) begin
              err_count_q <= err_count_d;
              if (!first_err_valid_q) begin
                first_err_valid_q <= 1'b1;
                first_err_vec_q   <= vec_q;
              end
            end
            // The final vector's own mismatch must count toward pass.
            if (vec_q == 4'hF) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_d == 5'd0);
            end else begin
              vec_q <= vec_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.a_out           = vec_q[3];
  assign bus.b_out           = vec_q[2];
  assign bus.c_out           = vec_q[1];
  assign bus.d_out           = vec_q[0];
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_count_q;
  assign bus.first_err_valid = first_err_valid_q;
  assign bus.first_err_vec   = first_err_vec_q;
  assign bus.captured        = captured_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: one instance with a 10-cycle hold, one with a 1-cycle
// hold, each looped back through a table-driven model of the combinational DUT.
module tb_truth_table_checker;

  logic clk;
  logic rst;

  truth_table_checker_if if10 ();
  truth_table_checker_if if1 ();

  truth_table_checker #(.HOLD_CYCLES(10)) u_dut10 (.clk(clk), .rst(rst), .bus(if10.slave));
  truth_table_checker #(.HOLD_CYCLES(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1.slave));

  logic [15:0] model10, model1;
  logic        tie0_10;
  logic [3:0]  vec10, vec1;

  assign vec10     = {if10.a_out, if10.b_out, if10.c_out, if10.d_out};
  assign vec1      = {if1.a_out, if1.b_out, if1.c_out, if1.d_out};
  assign if10.y_in = tie0_10 ? 1'b0 : model10[vec10];
  assign if1.y_in  = model1[vec1];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start10(input logic [15:0] exp_tt);
    if10.expected = exp_tt;
    if10.start    = 1'b1;
    tick(1);
    if10.start    = 1'b0;
  endtask

  task automatic chk_results10(input string tag, input logic [15:0] cap, input logic [4:0] errs,
                               input logic fvalid, input logic [3:0] fvec, input logic pass);
    chk({tag, "_done"}, {31'd0, if10.done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, if10.busy}, 32'd0);
    chk({tag, "_captured"}, {16'd0, if10.captured}, {16'd0, cap});
    chk({tag, "_err_count"}, {27'd0, if10.err_count}, {27'd0, errs});
    chk({tag, "_first_valid"}, {31'd0, if10.first_err_valid}, {31'd0, fvalid});
    chk({tag, "_first_vec"}, {28'd0, if10.first_err_vec}, {28'd0, fvec});
    chk({tag, "_pass"}, {31'd0, if10.pass}, {31'd0, pass});
  endtask

  initial begin
    rst           = 1'b1;
    if10.start    = 1'b0;
    if10.expected = 16'h0000;
    if1.start     = 1'b0;
    if1.expected  = 16'h0000;
    model10       = 16'hF0F0;
    model1        = 16'h6996;
    tie0_10       = 1'b0;
    tick(2);

    // Reset state
    chk("rst_outputs10", {if10.busy, if10.done, if10.pass, if10.first_err_valid, vec10,
                          if10.first_err_vec, if10.err_count, if10.captured}, 32'd0);
    chk("rst_outputs1", {if1.busy, if1.done, if1.pass, if1.captured}, 32'd0);
    rst = 1'b0;
    tick(1);

    // Clean loopback sweep, checking the vector timing along the way
    start10(16'hF0F0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("vec_enter_%0d", k), {28'd0, vec10}, k);
      tick(9);
      chk($sformatf("vec_hold_%0d", k), {27'd0, if10.done, vec10}, k);
      tick(1);
    end
    chk_results10("sweep_f0f0", 16'hF0F0, 5'd0, 1'b0, 4'd0, 1'b1);
    chk("sweep_f0f0_vec_end", {28'd0, vec10}, 32'd15);

    // Single mismatch on vector 0
    start10(16'hF0F1);
    chk("restart_clears_done", {30'd0, if10.done, if10.busy}, 32'd1);
    tick(160);
    chk_results10("sweep_f0f1", 16'hF0F0, 5'd1, 1'b1, 4'd0, 1'b0);

    // Every vector mismatches: err_count reaches 16 without wrapping
    tie0_10 = 1'b1;
    start10(16'hFFFF);
    tick(160);
    chk_results10("sweep_all_bad", 16'h0000, 5'd16, 1'b1, 4'd0, 1'b0);
    tie0_10 = 1'b0;

    // Asynchronous reset during vector 7 discards partial results
    start10(16'hF0F1);
    tick(75);
    chk("pre_rst_vec", {28'd0, vec10}, 32'd7);
    chk("pre_rst_err", {27'd0, if10.err_count}, 32'd1);
    chk("pre_rst_captured", {16'd0, if10.captured}, 32'h0070);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {if10.busy, if10.done, if10.pass, if10.first_err_valid, vec10,
                              if10.first_err_vec, if10.err_count, if10.captured}, 32'd0);
    #3 rst = 1'b0;
    tick(1);
    start10(16'hF0F0);
    tick(160);
    chk_results10("after_rst", 16'hF0F0, 5'd0, 1'b0, 4'd0, 1'b1);

    // start and expected disturbed mid-sweep are both ignored
    model10 = 16'h6996;
    start10(16'h6996);
    tick(35);
    if10.start    = 1'b1;
    if10.expected = 16'h0000;
    tick(1);
    if10.start    = 1'b0;
    chk("ignore_start_vec", {27'd0, if10.busy, vec10}, 32'h13);
    tick(124);
    chk_results10("ignore_start", 16'h6996, 5'd0, 1'b0, 4'd0, 1'b1);

    // One-cycle hold with start held: done pulses once every 17 cycles
    if1.expected = 16'h6996;
    if1.start    = 1'b1;
    tick(1);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("h1_vec_s%0d", s), {27'd0, if1.done, vec1}, 32'd0);
      tick(15);
      chk($sformatf("h1_not_done_s%0d", s), {31'd0, if1.done}, 32'd0);
      tick(1);
      chk($sformatf("h1_done_s%0d", s), {30'd0, if1.done, if1.pass}, 32'd3);
      chk($sformatf("h1_captured_s%0d", s), {16'd0, if1.captured}, 32'h6996);
      tick(1);
      chk($sformatf("h1_restart_s%0d", s), {30'd0, if1.done, if1.busy}, 32'd1);
    end
    if1.start = 1'b0;
    tick(20);
    chk("h1_final", {29'd0, if1.done, if1.pass, if1.busy}, 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
